// File: rtl/input_conditioner_pkg.sv
// Shared types for the input conditioner: per-bit debouncer state encoding.
package input_conditioner_pkg;

    typedef enum logic {
        DB_IDLE     = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: synchroniser chain, disagreement counter, debounced level and edge pulses.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// DB_IDLE     | sync_q agrees with stable_out (or just flipped), count is 0
// DB_COUNTING | sync_q disagrees with stable_out, count holds cycles seen so far
module debounce_cell
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;

    db_state_t        state_r;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt;
    logic             differ;
    logic             flip;

    logic stable_nxt;
    logic rise_nxt;
    logic fall_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= DB_IDLE;
            count_r    <= '0;
            stable_out <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            count_r    <= count_nxt;
            stable_out <= stable_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // Terminal count reached on the disagreeing cycle itself; with one-cycle debounce this fires from IDLE.
    assign differ = sync_q ^ stable_out;
    assign flip   = differ && (count_r == CNT_LAST);

    always_comb begin
        state_nxt = state_r;
        count_nxt = count_r;
        case (state_r)
            DB_IDLE: begin
                count_nxt = '0;
                if (differ && !flip) begin
                    state_nxt = DB_COUNTING;
                    count_nxt = CNT_ONE;
                end else begin
                    state_nxt = DB_IDLE;
                end
            end
            DB_COUNTING: begin
                if (!differ || flip) begin
                    state_nxt = DB_IDLE;
                    count_nxt = '0;
                end else begin
                    state_nxt = DB_COUNTING;
                    count_nxt = count_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        stable_nxt  = stable_out;
        rise_nxt    = 1'b0;
        fall_nxt    = 1'b0;
        change_next = 1'b0;
        if (flip) begin
            stable_nxt  = sync_q;
            rise_nxt    = sync_q;
            fall_nxt    = ~sync_q;
            change_next = 1'b1;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Five-bit switch input stage: per-bit sync + debounce, registered rise/fall pulses and a combined change flag.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    logic [WIDTH-1:0] change_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .raw_in      (raw_in[i]),
            .stable_out  (stable_out[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .change_next (change_next[i])
        );
    end

    // Registered from the cells' flip decisions so it lines up with the pulse flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |change_next;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: vector table for step/bounce/simultaneous cases, hand sequences for reset and default latency.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] raw_in;
    logic [4:0] stable_out;
    logic [4:0] rise_pulse;
    logic [4:0] fall_pulse;
    logic       any_change;

    logic       rst_d;
    logic [4:0] raw_d;
    logic [4:0] stable_d;
    logic [4:0] rise_d;
    logic [4:0] fall_d;
    logic       any_d;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] st;
        logic [4:0] ri;
        logic [4:0] fa;
        logic       an;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    input_conditioner #(
        .WIDTH           (5),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    input_conditioner dut_def (
        .clk        (clk),
        .rst        (rst_d),
        .raw_in     (raw_d),
        .stable_out (stable_d),
        .rise_pulse (rise_d),
        .fall_pulse (fall_d),
        .any_change (any_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] st, input logic [4:0] ri,
                           input logic [4:0] fa, input logic an);
        chk({tag, " stable"}, 32'(stable_out), 32'(st));
        chk({tag, " rise"},   32'(rise_pulse), 32'(ri));
        chk({tag, " fall"},   32'(fall_pulse), 32'(fa));
        chk({tag, " any"},    32'(any_change), 32'(an));
    endtask

    task automatic add_vec(input logic [4:0] r, input logic [4:0] s, input logic [4:0] ri,
                           input logic [4:0] fa, input logic an);
        vec_t v;
        v.raw = r; v.st = s; v.ri = ri; v.fa = fa; v.an = an;
        vecs.push_back(v);
    endtask

    initial begin
        logic [4:0] b0_seq [15];
        int         rise4_cnt;

        // clean step on bit 2: flip on edge 6
        for (int e = 1; e <= 8; e++)
            add_vec(5'b00100, (e >= 6) ? 5'b00100 : 5'b00000,
                    (e == 6) ? 5'b00100 : 5'b00000, 5'b00000, e == 6);
        // bounce on bit 0: 1,1,1,0,1,1,1,0 then steady 1; flip on edge 14
        b0_seq = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
        for (int e = 1; e <= 15; e++)
            add_vec({4'b0010, b0_seq[e-1][0]}, (e >= 14) ? 5'b00101 : 5'b00100,
                    (e == 14) ? 5'b00001 : 5'b00000, 5'b00000, e == 14);
        // every bit flips at once
        for (int e = 1; e <= 7; e++)
            add_vec(5'b11010, (e >= 6) ? 5'b11010 : 5'b00101,
                    (e == 6) ? 5'b11010 : 5'b00000, (e == 6) ? 5'b00101 : 5'b00000, e == 6);

        rst    = 1'b1;
        rst_d  = 1'b1;
        raw_in = 5'b11111;
        raw_d  = 5'b00000;

        // reset with all inputs high
        repeat (3) step();
        chk_all("s1 in reset", 5'b00000, 5'b00000, 5'b00000, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk_all($sformatf("s1 e%0d", e), (e >= 6) ? 5'b11111 : 5'b00000,
                    (e == 6) ? 5'b11111 : 5'b00000, 5'b00000, e == 6);
        end

        // drop bit 4 so it can be raised again in the reset-mid-count case
        raw_in = 5'b01111;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk_all($sformatf("s4pre e%0d", e), (e >= 6) ? 5'b01111 : 5'b11111,
                    5'b00000, (e == 6) ? 5'b10000 : 5'b00000, e == 6);
        end

        // reset mid-count on bit 4
        raw_in = 5'b11111;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk_all($sformatf("s4 count e%0d", e), 5'b01111, 5'b00000, 5'b00000, 1'b0);
        end
        #2 rst = 1'b1;
        #1 chk_all("s4 async clear", 5'b00000, 5'b00000, 5'b00000, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        rise4_cnt = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            rise4_cnt += int'(rise_pulse[4]);
            chk_all($sformatf("s4 post e%0d", e), (e >= 6) ? 5'b11111 : 5'b00000,
                    (e == 6) ? 5'b11111 : 5'b00000, 5'b00000, e == 6);
        end
        chk("s4 rise4 count", 32'(rise4_cnt), 32'd1);

        // clear everything back to zero for the vector table
        raw_in = 5'b00000;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        chk_all("tbl start", 5'b00000, 5'b00000, 5'b00000, 1'b0);

        foreach (vecs[i]) begin
            raw_in = vecs[i].raw;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ri, vecs[i].fa, vecs[i].an);
        end

        // default parameters: 2 + 16 = edge 18
        raw_d = 5'b00010;
        rst_d = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            step();
            chk($sformatf("s5 rise e%0d", e), 32'(rise_d), (e == 18) ? 32'h2 : 32'h0);
            chk($sformatf("s5 stable e%0d", e), 32'(stable_d), (e >= 18) ? 32'h2 : 32'h0);
        end
        raw_d = 5'b00000;
        for (int e = 1; e <= 19; e++) begin
            step();
            chk($sformatf("s5 fall e%0d", e), 32'(fall_d), (e == 18) ? 32'h2 : 32'h0);
            chk($sformatf("s5 any e%0d", e), 32'(any_d), (e == 18) ? 32'h1 : 32'h0);
            chk($sformatf("s5 stable2 e%0d", e), 32'(stable_d), (e >= 18) ? 32'h0 : 32'h2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
